// File: rtl/wb_onewire_if.sv
// Wishbone classic bus bundle between the conbus interconnect and the 1-Wire master.
interface wb_onewire_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_onewire_master.sv
// Wishbone-mapped 1-Wire master: reset, bit and byte commands with 1 us slot timing,
// open-drain pull-down drive, line sampling and a completion interrupt.
module wb_onewire_master #(
    parameter int clk_freq = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    wb_onewire_if.slave wb,
    output logic        ow_pd_o,
    input  logic        ow_i,
    output logic        intr
);

    localparam logic [15:0] CLKDIV_RST = 16'(clk_freq / 1000000 - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RST_LO  = 3'd1;
    localparam logic [2:0] S_RST_HI  = 3'd2;
    localparam logic [2:0] S_SLOT_LO = 3'd3;
    localparam logic [2:0] S_SLOT_HI = 3'd4;
    localparam logic [2:0] S_RECOV   = 3'd5;

    logic [2:0]  r_state;
    logic [15:0] r_presc;
    logic [15:0] r_clkdiv;
    logic [9:0]  r_usec;
    logic [7:0]  r_tx_data;
    logic [7:0]  r_tx;
    logic [7:0]  r_rx;
    logic [7:0]  r_rx_data;
    logic [2:0]  r_bitcnt;
    logic        r_is_read;
    logic        r_presence;
    logic        r_last;
    logic        r_overrun;
    logic        r_done;
    logic        r_ie;
    logic        r_ow_s1;
    logic        r_ow_s2;
    logic        r_ow_pd;
    logic        r_ack;
    logic [31:0] r_dat;

    logic        w_req;
    logic        w_wr;
    logic        w_ctrl_wr;
    logic        w_tick;
    logic        w_busy;
    logic        w_start;
    logic        w_sample;
    logic        w_finish;
    logic [2:0]  w_next;
    logic [2:0]  w_state_d;
    logic [9:0]  w_lo_len;
    logic [31:0] w_rd;
    logic        w_unused;

    assign w_req     = wb.wb_stb_i & wb.wb_cyc_i & ~r_ack;
    assign w_wr      = w_req & wb.wb_we_i;
    assign w_ctrl_wr = w_wr & (wb.wb_adr_i[3:2] == 2'd0);
    assign w_tick    = (r_presc == r_clkdiv);
    assign w_busy    = (r_state != S_IDLE);
    // A new command may start on the very edge the previous one completes.
    assign w_start   = w_ctrl_wr & (|wb.wb_dat_i[4:0]) & (~w_busy | w_finish);
    assign w_state_d = w_start ? (wb.wb_dat_i[0] ? S_RST_LO : S_SLOT_LO) : w_next;
    assign w_lo_len  = (r_is_read | r_tx[0]) ? 10'd6 : 10'd60;
    assign w_unused  = ^{wb.wb_sel_i, wb.wb_adr_i[31:4], wb.wb_adr_i[1:0], wb.wb_dat_i[31:16]};

    assign wb.wb_ack_o = r_ack;
    assign wb.wb_dat_o = r_dat;
    assign ow_pd_o     = r_ow_pd;
    assign intr        = r_done & r_ie;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next   = r_state;
        w_sample = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            S_IDLE:    w_next = S_IDLE;
            S_RST_LO:  if (w_tick && r_usec == 10'd479) w_next = S_RST_HI;
            S_RST_HI: begin
                w_sample = w_tick && (r_usec == 10'd69);
                if (w_tick && r_usec == 10'd409) begin
                    w_next   = S_IDLE;
                    w_finish = 1'b1;
                end
            end
            S_SLOT_LO: if (w_tick && r_usec == w_lo_len - 10'd1) w_next = S_SLOT_HI;
            S_SLOT_HI: begin
                w_sample = w_tick && (r_usec == 10'd8);
                if (w_tick && r_usec == 10'd69 - w_lo_len) w_next = S_RECOV;
            end
            S_RECOV: begin
                if (w_tick && r_usec == 10'd1) begin
                    if (r_bitcnt != 3'd0) begin
                        w_next = S_SLOT_LO;
                    end else begin
                        w_next   = S_IDLE;
                        w_finish = 1'b1;
                    end
                end
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd = 32'h0;
        case (wb.wb_adr_i[3:2])
            2'd0:    w_rd = {24'h0, r_ie, 2'b00, r_done, r_overrun, r_last, r_presence, w_busy};
            2'd1:    w_rd = {24'h0, r_rx_data};
            2'd2:    w_rd = {16'h0, r_clkdiv};
            default: w_rd = 32'h0;
        endcase
    end

    // NOTE: state uses non-blocking assignments and an asynchronous reset, so the pull-down
    // releases the moment rst falls, without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ack     <= 1'b0;
            r_dat     <= 32'h0;
            r_clkdiv  <= CLKDIV_RST;
            r_tx_data <= 8'h0;
            r_ie      <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_ack <= w_req;
            r_dat <= (w_req & ~wb.wb_we_i) ? w_rd : 32'h0;
            if (w_wr && !w_busy && wb.wb_adr_i[3:2] == 2'd1) r_tx_data <= wb.wb_dat_i[7:0];
            if (w_wr && !w_busy && wb.wb_adr_i[3:2] == 2'd2) r_clkdiv  <= wb.wb_dat_i[15:0];
            if (w_ctrl_wr) begin
                r_ie      <= wb.wb_dat_i[7];
                r_done    <= 1'b0;
                r_overrun <= (|wb.wb_dat_i[4:0]) & ~w_start;
            end else if (w_finish) begin
                r_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_presc    <= 16'h0;
            r_usec     <= 10'h0;
            r_tx       <= 8'h0;
            r_rx       <= 8'h0;
            r_rx_data  <= 8'h0;
            r_bitcnt   <= 3'd0;
            r_is_read  <= 1'b0;
            r_presence <= 1'b0;
            r_last     <= 1'b0;
            r_ow_s1    <= 1'b1;
            r_ow_s2    <= 1'b1;
            r_ow_pd    <= 1'b0;
        end else begin
            r_ow_s1 <= ow_i;
            r_ow_s2 <= r_ow_s1;
            r_state <= w_state_d;
            r_ow_pd <= (w_state_d == S_RST_LO) || (w_state_d == S_SLOT_LO);
            r_presc <= (w_start || w_tick) ? 16'h0 : r_presc + 16'h1;
            if (w_state_d != r_state) r_usec <= 10'h0;
            else if (w_tick)          r_usec <= r_usec + 10'h1;

            if (w_sample) begin
                if (r_state == S_RST_HI) begin
                    r_presence <= ~r_ow_s2;
                end else begin
                    r_rx   <= {r_ow_s2, r_rx[7:1]};
                    r_last <= r_ow_s2;
                end
            end
            if (r_state == S_RECOV && w_next == S_SLOT_LO) begin
                r_bitcnt <= r_bitcnt - 3'd1;
                r_tx     <= {1'b0, r_tx[7:1]};
            end
            if (w_finish && r_state == S_RECOV) r_rx_data <= r_rx;

            // Lowest-numbered command bit wins when several are set.
            if (w_start) begin
                r_rx <= 8'h0;
                if (wb.wb_dat_i[0]) begin
                    r_presence <= 1'b0;
                end else if (wb.wb_dat_i[1]) begin
                    r_tx      <= {7'h0, wb.wb_dat_i[8]};
                    r_bitcnt  <= 3'd0;
                    r_is_read <= 1'b0;
                end else if (wb.wb_dat_i[2]) begin
                    r_tx      <= r_tx_data;
                    r_bitcnt  <= 3'd0;
                    r_is_read <= 1'b1;
                end else if (wb.wb_dat_i[3]) begin
                    r_tx      <= r_tx_data;
                    r_bitcnt  <= 3'd7;
                    r_is_read <= 1'b0;
                end else begin
                    r_tx      <= r_tx_data;
                    r_bitcnt  <= 3'd7;
                    r_is_read <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_onewire_master.sv
// Directed bench for wb_onewire_master: register access, reset/presence, byte write/read
// slot timing, overrun, command priority, done/write collision and async reset.
module tb_wb_onewire_master;

    localparam logic [31:0] A_CTRL = 32'h7000_0000;
    localparam logic [31:0] A_DATA = 32'h7000_0004;
    localparam logic [31:0] A_DIV  = 32'h7000_0008;
    localparam logic [31:0] A_RSV  = 32'h7000_000C;

    logic       clk = 1'b0;
    logic       rst;
    logic       ow_pd_o;
    logic       ow_i;
    logic       intr;
    logic       pres_low = 1'b0;
    logic       rd_low = 1'b0;
    int         slave_mode = 0;
    int         slot_idx = 0;
    logic [7:0] rd_pattern = 8'h3C;
    int         run_len = 0;
    int         lows[$];
    int         n_checks = 0;
    int         n_fail = 0;

    wb_onewire_if wb();

    wb_onewire_master #(.clk_freq(50000000)) dut (
        .clk     (clk),
        .rst     (rst),
        .wb      (wb),
        .ow_pd_o (ow_pd_o),
        .ow_i    (ow_i),
        .intr    (intr)
    );

    always #5 clk = ~clk;

    // Open-drain line with pull-up: low if the master or the slave model pulls it.
    assign ow_i = ~(ow_pd_o | pres_low | rd_low);

    always @(negedge clk) begin
        if (ow_pd_o) begin
            run_len++;
        end else if (run_len != 0) begin
            lows.push_back(run_len);
            run_len = 0;
        end
    end

    always @(negedge ow_pd_o) begin
        if (slave_mode == 1) begin
            repeat (20) @(posedge clk);
            pres_low = 1'b1;
            repeat (180) @(posedge clk);
            pres_low = 1'b0;
        end
    end

    always @(posedge ow_pd_o) begin
        if (slave_mode == 2) begin
            if (!rd_pattern[slot_idx]) begin
                rd_low = 1'b1;
                repeat (40) @(posedge clk);
                rd_low = 1'b0;
            end
            slot_idx++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_access(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                             output logic [31:0] rdata);
        int n;
        @(negedge clk);
        wb.wb_adr_i = adr;
        wb.wb_dat_i = dat;
        wb.wb_we_i  = we;
        wb.wb_stb_i = 1'b1;
        wb.wb_cyc_i = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wb.wb_ack_o && n < 8);
        rdata = wb.wb_dat_o;
        if (!wb.wb_ack_o) check("ack_timeout", {31'h0, wb.wb_ack_o}, 32'h1);
        wb.wb_stb_i = 1'b0;
        wb.wb_cyc_i = 1'b0;
        wb.wb_we_i  = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] unused_rd;
        wb_access(adr, dat, 1'b1, unused_rd);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdata);
        wb_access(adr, 32'h0, 1'b0, rdata);
    endtask

    task automatic wait_intr(input int limit, output int n);
        n = 0;
        while (!intr && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          n;
        int          base;

        rst         = 1'b0;
        wb.wb_adr_i = 32'h0;
        wb.wb_dat_i = 32'h0;
        wb.wb_sel_i = 4'hF;
        wb.wb_stb_i = 1'b0;
        wb.wb_cyc_i = 1'b0;
        wb.wb_we_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ow_pd", {31'h0, ow_pd_o}, 32'h0);
        check("rst_intr", {31'h0, intr}, 32'h0);
        check("rst_ack", {31'h0, wb.wb_ack_o}, 32'h0);
        @(negedge clk) rst = 1'b1;

        // Reset values and reserved slot
        wb_read(A_DIV, rd);   check("rst_clkdiv", rd, 32'h31);
        wb_read(A_CTRL, rd);  check("rst_stat", rd, 32'h0);
        wb_read(A_DATA, rd);  check("rst_data", rd, 32'h0);
        wb_write(A_RSV, 32'hFFFF_FFFF);
        wb_read(A_RSV, rd);   check("reserved_rd", rd, 32'h0);

        // Reset pulse with presence, 1 tick per clock
        wb_write(A_DIV, 32'h0);
        wb_read(A_DIV, rd);   check("clkdiv_wr", rd, 32'h0);
        slave_mode = 1;
        base = lows.size();
        wb_write(A_CTRL, 32'h81);
        wait_intr(2000, n);
        check("rst_busy_ticks", n, 890);
        check("rst_low_count", lows.size() - base, 1);
        if (lows.size() > base) check("rst_low_ticks", lows[base], 480);
        wb_read(A_CTRL, rd);  check("rst_stat_done", rd, 32'h92);
        slave_mode = 0;

        // WBYTE 0xA5, LSB first, no slave response
        wb_write(A_DATA, 32'hA5);
        base = lows.size();
        wb_write(A_CTRL, 32'h88);
        check("wbyte_intr_clr", {31'h0, intr}, 32'h0);
        wait_intr(2000, n);
        check("wbyte_ticks", n, 576);
        check("wbyte_intr", {31'h0, intr}, 32'h1);
        check("wbyte_low_count", lows.size() - base, 8);
        for (int i = 0; i < 8 && base + i < lows.size(); i++) begin
            check($sformatf("wbyte_low%0d", i), lows[base + i], (8'hA5 >> i) & 1 ? 6 : 60);
        end
        wb_read(A_DATA, rd);  check("wbyte_readback", rd, 32'hFF);
        wb_read(A_CTRL, rd);  check("wbyte_stat", rd, 32'h96);

        // RBYTE with slave returning 0x3C
        slot_idx   = 0;
        slave_mode = 2;
        base = lows.size();
        wb_write(A_CTRL, 32'h10);
        repeat (300) @(posedge clk);
        wb_read(A_CTRL, rd);  check("rbyte_busy", {31'h0, rd[0]}, 32'h1);
        repeat (400) @(posedge clk);
        slave_mode = 0;
        wb_read(A_DATA, rd);  check("rbyte_data", rd, 32'h3C);
        wb_read(A_CTRL, rd);  check("rbyte_stat", rd, 32'h12);
        check("rbyte_intr_off", {31'h0, intr}, 32'h0);
        check("rbyte_low_count", lows.size() - base, 8);
        for (int i = 0; i < 8 && base + i < lows.size(); i++) begin
            check($sformatf("rbyte_low%0d", i), lows[base + i], 6);
        end

        // Command while busy is ignored and flags overrun
        wb_write(A_DATA, 32'h00);
        base = lows.size();
        wb_write(A_CTRL, 32'h08);
        repeat (100) @(posedge clk);
        wb_write(A_DATA, 32'h55);
        wb_write(A_CTRL, 32'h04);
        wb_read(A_CTRL, rd);  check("ovr_stat_busy", rd, 32'h0F);
        repeat (600) @(posedge clk);
        wb_read(A_CTRL, rd);  check("ovr_stat_done", rd, 32'h1E);
        check("ovr_low_count", lows.size() - base, 8);
        for (int i = 0; i < 8 && base + i < lows.size(); i++) begin
            check($sformatf("ovr_low%0d", i), lows[base + i], 60);
        end
        wb_write(A_CTRL, 32'h00);
        wb_read(A_CTRL, rd);  check("ovr_cleared", rd, 32'h06);

        // Multi-bit command: WBIT (value 0) beats RBYTE
        base = lows.size();
        wb_write(A_CTRL, 32'h92);
        wait_intr(500, n);
        check("prio_ticks", n, 72);
        check("prio_low_count", lows.size() - base, 1);
        if (lows.size() > base) check("prio_low", lows[base], 60);
        wb_read(A_DATA, rd);  check("prio_rx", rd, 32'h80);
        wb_read(A_CTRL, rd);  check("prio_stat", rd, 32'h96);

        // CTRL write on the same edge done would set: the write wins
        wb_write(A_CTRL, 32'h182);
        repeat (71) @(posedge clk);
        wb_write(A_CTRL, 32'h80);
        check("collide_intr", {31'h0, intr}, 32'h0);
        wb_read(A_CTRL, rd);  check("collide_stat", rd, 32'h86);

        // Asynchronous reset 30 us into the reset pulse
        wb_write(A_CTRL, 32'h01);
        repeat (30) @(posedge clk);
        #2;
        check("mid_rst_pd_before", {31'h0, ow_pd_o}, 32'h1);
        rst = 1'b0;
        #1;
        check("mid_rst_pd_release", {31'h0, ow_pd_o}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wb_read(A_CTRL, rd);  check("post_rst_stat", rd, 32'h0);
        wb_read(A_DIV, rd);   check("post_rst_clkdiv", rd, 32'h31);
        wb_read(A_DATA, rd);  check("post_rst_data", rd, 32'h0);
        check("post_rst_ow_pd", {31'h0, ow_pd_o}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
